// File: rtl/game_ctrl.sv
// Pong-style game controller: serve/play/score sequencing, ball motion with
// wall and paddle bounces, and per-player scoring, advanced once per video frame.
module game_ctrl #(
    parameter int FIELD_W   = 640,
    parameter int FIELD_H   = 480,
    parameter int WIN_SCORE = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       bat_size,
    input  logic       en,
    input  logic       en2,
    input  logic [1:0] mode,
    input  logic [9:0] pad1_y,
    input  logic [9:0] pad2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_SCORE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [9:0]         CX     = 10'(FIELD_W / 2 - 4);
    localparam logic [9:0]         CY     = 10'(FIELD_H / 2 - 4);
    localparam logic signed [10:0] X_LIM  = 11'(FIELD_W - 8);
    localparam logic signed [10:0] Y_LIM  = 11'(FIELD_H - 8);
    localparam logic signed [10:0] PAD_R  = 11'(FIELD_W - 32);
    localparam logic signed [10:0] PAD_L  = 11'sd24;
    localparam logic signed [10:0] ZERO   = 11'sd0;
    localparam logic [3:0]         WIN    = 4'(WIN_SCORE);

    state_t     r_state, w_state;
    logic [9:0] r_x, r_y, w_x, w_y;
    logic       r_dx, r_dy, w_dx, w_dy;      // dx=1 moving right, dy=1 moving down
    logic [3:0] r_s1, r_s2, w_s1, w_s2;
    logic [2:0] r_speed, w_speed;
    logic [5:0] r_cnt, w_cnt;
    logic       r_serve_left, w_serve_left;  // left player conceded the last point

    logic signed [10:0] w_spd, w_nx, w_ny;
    logic [10:0]        w_by, w_h;
    logic               w_ov1, w_ov2;

    assign w_spd = $signed({8'd0, r_speed});
    assign w_nx  = r_dx ? $signed({1'b0, r_x}) + w_spd : $signed({1'b0, r_x}) - w_spd;
    assign w_ny  = r_dy ? $signed({1'b0, r_y}) + w_spd : $signed({1'b0, r_y}) - w_spd;

    // Paddle overlap uses the ball's current row, not the projected one.
    assign w_by  = {1'b0, r_y};
    assign w_h   = bat_size ? 11'd64 : 11'd32;
    assign w_ov1 = (w_by + 11'd8 > {1'b0, pad1_y}) && (w_by < {1'b0, pad1_y} + w_h);
    assign w_ov2 = (w_by + 11'd8 > {1'b0, pad2_y}) && (w_by < {1'b0, pad2_y} + w_h);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_x          <= CX;
            r_y          <= CY;
            r_dx         <= 1'b1;
            r_dy         <= 1'b1;
            r_s1         <= 4'd0;
            r_s2         <= 4'd0;
            r_speed      <= 3'd1;
            r_cnt        <= 6'd0;
            r_serve_left <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_x          <= w_x;
            r_y          <= w_y;
            r_dx         <= w_dx;
            r_dy         <= w_dy;
            r_s1         <= w_s1;
            r_s2         <= w_s2;
            r_speed      <= w_speed;
            r_cnt        <= w_cnt;
            r_serve_left <= w_serve_left;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_x          = r_x;
        w_y          = r_y;
        w_dx         = r_dx;
        w_dy         = r_dy;
        w_s1         = r_s1;
        w_s2         = r_s2;
        w_speed      = r_speed;
        w_cnt        = r_cnt;
        w_serve_left = r_serve_left;

        case (r_state)
            S_IDLE, S_OVER: begin
                w_x = CX;
                w_y = CY;
                if (start) begin
                    w_state = S_SERVE;
                    w_s1    = 4'd0;
                    w_s2    = 4'd0;
                    w_cnt   = 6'd0;
                    w_dx    = 1'b1;
                    w_dy    = 1'b1;
                end
            end

            S_SERVE: begin
                if (frame_tick) begin
                    w_speed = {1'b0, mode} + 3'd1;
                    w_x     = CX;
                    w_y     = CY;
                    if (r_cnt == 6'd31) begin
                        w_state = S_PLAY;
                        w_cnt   = 6'd0;
                    end else begin
                        w_cnt = r_cnt + 6'd1;
                    end
                end
            end

            S_PLAY: begin
                if (frame_tick) begin
                    if (w_ny <= ZERO) begin
                        w_y  = 10'd0;
                        w_dy = 1'b1;
                    end else if (w_ny >= Y_LIM) begin
                        w_y  = Y_LIM[9:0];
                        w_dy = 1'b0;
                    end else begin
                        w_y = w_ny[9:0];
                    end

                    // Paddle hits take priority over misses on the same side.
                    if (!r_dx) begin
                        if (en && w_nx <= PAD_L && w_ov1) begin
                            w_x  = PAD_L[9:0];
                            w_dx = 1'b1;
                        end else if (w_nx <= ZERO) begin
                            w_x = 10'd0;
                            if (en) begin
                                w_s2         = (r_s2 == 4'hF) ? r_s2 : r_s2 + 4'd1;
                                w_state      = S_SCORE;
                                w_cnt        = 6'd0;
                                w_serve_left = 1'b1;
                            end else begin
                                w_dx = 1'b1;
                            end
                        end else begin
                            w_x = w_nx[9:0];
                        end
                    end else begin
                        if (en2 && w_nx >= PAD_R && w_ov2) begin
                            w_x  = PAD_R[9:0];
                            w_dx = 1'b0;
                        end else if (w_nx >= X_LIM) begin
                            w_x = X_LIM[9:0];
                            if (en2) begin
                                w_s1         = (r_s1 == 4'hF) ? r_s1 : r_s1 + 4'd1;
                                w_state      = S_SCORE;
                                w_cnt        = 6'd0;
                                w_serve_left = 1'b0;
                            end else begin
                                w_dx = 1'b0;
                            end
                        end else begin
                            w_x = w_nx[9:0];
                        end
                    end
                end
            end

            S_SCORE: begin
                if (frame_tick) begin
                    if (r_cnt == 6'd63) begin
                        w_cnt = 6'd0;
                        w_x   = CX;
                        w_y   = CY;
                        if (r_s1 == WIN || r_s2 == WIN) begin
                            w_state = S_OVER;
                        end else begin
                            w_state = S_SERVE;
                            w_dx    = ~r_serve_left;
                        end
                    end else begin
                        w_cnt = r_cnt + 6'd1;
                    end
                end
            end

            default: w_state = S_IDLE;
        endcase
    end

    assign ball_x = r_x;
    assign ball_y = r_y;
    assign score1 = r_s1;
    assign score2 = r_s2;
    assign state  = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl: a frame-level game model predicts every
// output after each clock edge; directed openings cover reset and a wall rally.
module tb_game_ctrl;

    localparam int FW  = 640;
    localparam int FH  = 480;
    localparam int WIN = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       bat_size = 1'b0;
    logic       en = 1'b0;
    logic       en2 = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [9:0] pad1_y = 10'd0;
    logic [9:0] pad2_y = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score1, score2;
    logic [2:0] state;

    game_ctrl #(.FIELD_W(FW), .FIELD_H(FH), .WIN_SCORE(WIN)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .bat_size(bat_size), .en(en), .en2(en2), .mode(mode),
        .pad1_y(pad1_y), .pad2_y(pad2_y), .ball_x(ball_x), .ball_y(ball_y),
        .score1(score1), .score2(score2), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [30:0] exp_q[$];

    // Game model: positions as plain integers, directions as +1/-1.
    int m_state, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_speed, m_cnt;
    int m_serve_dx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = FW / 2 - 4; m_y = FH / 2 - 4;
        m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0;
        m_speed = 1; m_cnt = 0; m_serve_dx = 1;
    endtask

    task automatic model_step();
        int nx, ny, old_y, h, p1, p2;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_state == 0 || m_state == 4) begin
            m_x = FW / 2 - 4; m_y = FH / 2 - 4;
            if (start) begin
                m_state = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0; m_dx = 1; m_dy = 1;
            end
            return;
        end
        if (!frame_tick) return;
        if (m_state == 1) begin
            m_speed = 1 + int'(mode);
            m_x = FW / 2 - 4; m_y = FH / 2 - 4;
            m_cnt++;
            if (m_cnt == 32) begin m_state = 2; m_cnt = 0; end
        end else if (m_state == 2) begin
            nx = m_x + m_dx * m_speed;
            ny = m_y + m_dy * m_speed;
            old_y = m_y;
            h = bat_size ? 64 : 32;
            p1 = int'(pad1_y);
            p2 = int'(pad2_y);
            if (ny <= 0) begin m_y = 0; m_dy = 1; end
            else if (ny >= FH - 8) begin m_y = FH - 8; m_dy = -1; end
            else m_y = ny;
            if (m_dx < 0) begin
                if (en && nx <= 24 && old_y + 8 > p1 && old_y < p1 + h) begin
                    m_x = 24; m_dx = 1;
                end else if (nx <= 0 && en) begin
                    m_x = 0; m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                    m_state = 3; m_cnt = 0; m_serve_dx = -1;
                end else if (nx <= 0) begin
                    m_x = 0; m_dx = 1;
                end else m_x = nx;
            end else begin
                if (en2 && nx >= FW - 32 && old_y + 8 > p2 && old_y < p2 + h) begin
                    m_x = FW - 32; m_dx = -1;
                end else if (nx >= FW - 8 && en2) begin
                    m_x = FW - 8; m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                    m_state = 3; m_cnt = 0; m_serve_dx = 1;
                end else if (nx >= FW - 8) begin
                    m_x = FW - 8; m_dx = -1;
                end else m_x = nx;
            end
        end else if (m_state == 3) begin
            m_cnt++;
            if (m_cnt == 64) begin
                m_cnt = 0;
                m_x = FW / 2 - 4; m_y = FH / 2 - 4;
                if (m_s1 == WIN || m_s2 == WIN) m_state = 4;
                else begin m_state = 1; m_dx = m_serve_dx; end
            end
        end
    endtask

    task automatic push_expected();
        exp_q.push_back({3'(m_state), 4'(m_s2), 4'(m_s1), 10'(m_y), 10'(m_x)});
    endtask

    task automatic compare_outputs();
        logic [30:0] e;
        if (exp_q.size() == 0) begin
            check("exp_queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("state",  32'(state),  32'(e[30:28]));
        check("score2", 32'(score2), 32'(e[27:24]));
        check("score1", 32'(score1), 32'(e[23:20]));
        check("ball_y", 32'(ball_y), 32'(e[19:10]));
        check("ball_x", 32'(ball_x), 32'(e[9:0]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        push_expected();
        #1;
        compare_outputs();
    endtask

    // Asynchronous reset must act before any clock edge.
    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        push_expected();
        #1;
        compare_outputs();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    function automatic logic [9:0] track(input int y);
        int t;
        t = y - int'($urandom_range(0, 40));
        if (t < 0) t = 0;
        return 10'(t);
    endfunction

    initial begin
        logic track1, track2;
        #2;
        apply_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ball_x", 32'(ball_x), 32'd316);
        check("rst_ball_y", 32'(ball_y), 32'd236);
        check("rst_scores", 32'({score1, score2}), 32'd0);

        // Wall rally at speed 1 with both edges walled.
        mode = 2'd0; en = 1'b0; en2 = 1'b0; start = 1'b1;
        cycle();
        check("start_to_serve", 32'(state), 32'd1);
        start = 1'b0; frame_tick = 1'b1;
        repeat (32) cycle();
        check("serve_to_play", 32'(state), 32'd2);
        cycle();
        check("first_move_x", 32'(ball_x), 32'd317);
        check("first_move_y", 32'(ball_y), 32'd237);
        repeat (315) cycle();
        check("wall_x", 32'(ball_x), 32'd632);
        check("wall_no_score", 32'({score1, score2}), 32'd0);
        check("wall_state", 32'(state), 32'd2);
        cycle();
        check("wall_rebound_x", 32'(ball_x), 32'd631);

        // Reset in the middle of play.
        apply_reset();
        check("midplay_rst_state", 32'(state), 32'd0);
        check("midplay_rst_x", 32'(ball_x), 32'd316);

        track1 = 1'b1; track2 = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (i % 400 == 0) begin
                en     = ($urandom_range(0, 3) != 0);
                en2    = ($urandom_range(0, 3) != 0);
                track1 = ($urandom_range(0, 3) != 0);
                track2 = ($urandom_range(0, 3) != 0);
            end
            frame_tick = 1'($urandom_range(0, 1));
            start      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bat_size = 1'($urandom_range(0, 1));
            pad1_y = track1 ? track(m_y) : 10'($urandom_range(0, FH - 1));
            pad2_y = track2 ? track(m_y) : 10'($urandom_range(0, FH - 1));
            if ($urandom_range(0, 2999) == 0) begin
                apply_reset();
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter FIELD_W, default 640, meaning playfield width in pixels.
REQ-002 SHALL have parameter FIELD_H, default 480, meaning playfield height in pixels.
REQ-003 SHALL have parameter WIN_SCORE, default 9, meaning the points that end a game.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame, at start of vblank.
REQ-007 SHALL have port start  input  1  level; starts a game from IDLE or OVER.
REQ-008 SHALL have port bat_size  input  1  paddle height: 0 = 32 px, 1 = 64 px.
REQ-009 SHALL have port en  input  1  left paddle present; 0 = left edge is a wall.
REQ-010 SHALL have port en2  input  1  right paddle present; 0 = right edge is a wall.
REQ-011 SHALL have port mode  input  2  ball speed, 1 + mode px/frame on each axis.
REQ-012 SHALL have ports pad1_y and pad2_y  input  10  paddle top y for left and right paddles.
REQ-013 SHALL have ports ball_x and ball_y  output  10  top-left corner of the 8x8 ball.
REQ-014 SHALL have ports score1 and score2  output  4  points for left and right players.
REQ-015 SHALL have port state  output  3  encoding IDLE=0, SERVE=1, PLAY=2, SCORE=3, OVER=4.

Function
REQ-016 SHALL update all state, position and score only on clk edges where frame_tick=1, except IDLE/OVER->SERVE on start; outputs registered, valid the cycle after the tick.
REQ-017 SHALL in IDLE hold the ball at centre (316,236) and move to SERVE on start=1, clearing both scores.
REQ-018 SHALL in SERVE hold the ball at centre, latch mode into the speed register, count 32 frames, then enter PLAY.
REQ-019 SHALL in PLAY compute next x/y as 11-bit signed current +/- speed per direction bit, then apply REQ-020..REQ-024.
REQ-020 Top/bottom: next_y<=0 -> y=0, dy down; next_y>=FIELD_H-8 -> y=FIELD_H-8, dy up.
REQ-021 Left paddle (en=1): moving left, next_x<=24, ball_y+8>pad1_y and ball_y<pad1_y+height -> x=24, dx right.
REQ-022 Right paddle (en2=1): moving right, next_x>=FIELD_W-32, same overlap test with pad2_y -> x=FIELD_W-32, dx left.
REQ-023 Miss: next_x<=0 with en=1 -> score2+1, enter SCORE; next_x>=FIELD_W-8 with en2=1 -> score1+1, enter SCORE.
REQ-024 Wall: en=0 and next_x<=0 -> x=0, dx right; en2=0 and next_x>=FIELD_W-8 -> x=FIELD_W-8, dx left; no score.
REQ-025 SHALL apply paddle checks before miss checks; a frame with both a y bounce and an x event SHALL apply both.
REQ-026 SHALL sample bat_size every frame; mode changes during PLAY SHALL take effect only at the next SERVE.
REQ-027 SHALL in SCORE freeze the ball for 64 frames, then enter OVER if either score equals WIN_SCORE, else SERVE.
REQ-028 SHALL serve with dx toward the player who conceded the last point; first serve SHALL go right and down; dy SHALL be kept across serves.
REQ-029 SHALL in OVER hold the scores and the ball at centre; start=1 SHALL enter SERVE with the scores cleared.
REQ-030 SHALL saturate scores at 15 and never wrap.

Reset
REQ-031 SHALL on rst=1 immediately force state=IDLE, ball=(316,236), dx right, dy down, scores=0, speed=1, counters=0, regardless of state.
REQ-032 SHALL ignore frame_tick and start while rst=1 and resume on the first edge after release.

Verification
REQ-033 Reset mid-PLAY with ball at (100,50) -> next cycle state=0, ball (316,236), scores 0.
REQ-034 start, mode=00, en=en2=0, 32 ticks -> PLAY; one tick later ball=(317,237); x wall bounce at 632 without scoring.
REQ-035 mode=11, ball moving up at y=2 -> after one tick y=0, dy down; next tick y=4.
REQ-036 en=1, bat_size=0, pad1_y=200, ball left-moving at (26,210), speed 2 -> x=24, dx right, no score change.
REQ-037 Same with pad1_y=400 -> SCORE, score2=1; 64 ticks later SERVE, serve dx left.
REQ-038 score1=8, right miss -> score1=9, after 64 ticks state=4; start -> SERVE, scores 0.
